playback_sequencer: RTL and testbench

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

---
 rtl/playback_sequencer.sv | 162 ++++++++++++++++
 tb/tb_playback_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// Playback sequencer: replays a latched pattern of 3-bit symbols as one-hot LED flashes,
// each symbol lit for ON_CYC cycles and followed by OFF_CYC blank cycles.
module playback_sequencer #(
    parameter int MAX_LEN = 25,
    parameter int ON_CYC  = 16,
    parameter int OFF_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [4:0]             length,
    input  logic                   reverse,
    input  logic [3*MAX_LEN-1:0]   pattern,
    output logic [7:0]             led,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             sym_idx
);

    localparam int PW      = 3 * MAX_LEN;
    localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [4:0]    MAX_LEN_W = 5'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   pat_r, pat_s;
    logic            rev_r, rev_s;
    logic [4:0]      len_r, len_s;
    logic [4:0]      idx_r, idx_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [4:0]      pos_s;
    logic [7:0]      led_r, led_s;
    logic            busy_r, done_r;

    // Symbol k lives at bits [3k+2:3k]; a shift keeps the selection in range for any k.
    function automatic logic [2:0] sym_sel(input logic [PW-1:0] pat, input logic [4:0] k);
        logic [PW-1:0] sh;
        sh = pat >> ({3'd0, k} * 8'd3);
        return sh[2:0];
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] v);
        return 8'd1 << v;
    endfunction

    // Next-state, next latched-context and next counter/index logic.
    always_comb begin
        state_s = state_r;
        pat_s   = pat_r;
        rev_s   = rev_r;
        len_s   = len_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        if (abort) begin
            state_s = ST_IDLE;
            idx_s   = 5'd0;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_s = 5'd0;
                    cnt_s = CNT_ZERO;
                    if (start) begin
                        pat_s   = pattern;
                        rev_s   = reverse;
                        len_s   = (length > MAX_LEN_W) ? MAX_LEN_W : length;
                        state_s = (len_s == 5'd0) ? ST_DONE : ST_ON;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ON: begin
                    if (cnt_r == ON_LAST) begin
                        state_s = ST_OFF;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (cnt_r == OFF_LAST) begin
                        cnt_s = CNT_ZERO;
                        if (idx_r == (len_r - 5'd1)) begin
                            state_s = ST_DONE;
                            idx_s   = 5'd0;
                        end else begin
                            state_s = ST_ON;
                            idx_s   = idx_r + 5'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                    idx_s   = 5'd0;
                    cnt_s   = CNT_ZERO;
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = 5'd0;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // LED value for the upcoming cycle, computed from the context that will be held then,
    // so the first ON cycle already shows the freshly latched pattern.
    always_comb begin
        pos_s = rev_s ? idx_s : (len_s - 5'd1 - idx_s);
        if (state_s == ST_ON) begin
            led_s = onehot8(sym_sel(pat_s, pos_s));
        end else begin
            led_s = 8'd0;
        end
    end

    // State, latched context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pat_r   <= {PW{1'b0}};
            rev_r   <= 1'b0;
            len_r   <= 5'd0;
            idx_r   <= 5'd0;
            cnt_r   <= CNT_ZERO;
            led_r   <= 8'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pat_r   <= pat_s;
            rev_r   <= rev_s;
            len_r   <= len_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            led_r   <= led_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign led     = led_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign sym_idx = idx_r;

endmodule

// File: tb/tb_playback_sequencer.sv
// Randomized self-checking bench for playback_sequencer against a cycle-list reference model.
module tb_playback_sequencer;

    localparam int MAX_LEN = 25;
    localparam int ON_CYC  = 2;
    localparam int OFF_CYC = 1;
    localparam int PW      = 3 * MAX_LEN;

    typedef struct {
        logic [7:0] led;
        logic       busy;
        logic       done;
        logic [4:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [4:0]    length;
    logic          reverse;
    logic [PW-1:0] pattern;
    logic [7:0]    led;
    logic          busy;
    logic          done;
    logic [4:0]    sym_idx;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t idle_e;

    playback_sequencer #(.MAX_LEN(MAX_LEN), .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .length(length),
        .reverse(reverse), .pattern(pattern), .led(led), .busy(busy), .done(done),
        .sym_idx(sym_idx)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check_val({tag, ".led"},  32'(led),     32'(e.led));
        check_val({tag, ".busy"}, 32'(busy),    32'(e.busy));
        check_val({tag, ".done"}, 32'(done),    32'(e.done));
        check_val({tag, ".idx"},  32'(sym_idx), 32'(e.idx));
    endtask

    function automatic logic [PW-1:0] rnd_pat();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    task automatic scramble_inputs();
        pattern = rnd_pat();
        length  = 5'($urandom_range(0, 31));
        reverse = 1'($urandom_range(0, 1));
    endtask

    // Expected per-cycle outputs following the start edge, derived from the playback rules.
    task automatic build_model(input logic [PW-1:0] pat, input int len_in, input logic rev);
        int            eff;
        int            k;
        logic [PW-1:0] sh;
        exp_t          e;
        eff = (len_in > MAX_LEN) ? MAX_LEN : len_in;
        exp_q.delete();
        for (int i = 0; i < eff; i++) begin
            k  = rev ? i : (eff - 1 - i);
            sh = pat >> (3 * k);
            e.led = 8'd1 << sh[2:0]; e.busy = 1'b1; e.done = 1'b0; e.idx = 5'(i);
            for (int c = 0; c < ON_CYC; c++) exp_q.push_back(e);
            e.led = 8'd0;
            for (int c = 0; c < OFF_CYC; c++) exp_q.push_back(e);
        end
        e.led = 8'd0; e.busy = 1'b1; e.done = 1'b1; e.idx = 5'd0;
        exp_q.push_back(e);
    endtask

    // Entry/exit at 1 time unit after a posedge.
    task automatic run_play(input logic [PW-1:0] pat, input int len_in, input logic rev,
                            input int mid_at, input int abort_at, input int rst_at);
        pattern = pat;
        length  = 5'(len_in);
        reverse = rev;
        start   = 1'b1;
        build_model(pat, len_in, rev);
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        for (int k = 0; k < exp_q.size(); k++) begin
            check_out($sformatf("play%0d[%0d]", len_in, k), exp_q[k]);
            if (k == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check_out("abort", idle_e);
                repeat (3) begin
                    @(posedge clk); #1;
                    check_out("post_abort", idle_e);
                end
                return;
            end
            if (k == rst_at) begin
                #3 rst_n = 1'b0;
                #1 check_out("async_rst", idle_e);
                #2 rst_n = 1'b1;
                repeat (2) begin
                    @(posedge clk); #1;
                    check_out("post_rst", idle_e);
                end
                return;
            end
            if (k == mid_at) begin
                start = 1'b1;
                scramble_inputs();
            end
            @(posedge clk); #1;
            start = 1'b0;
            scramble_inputs();
        end
        check_out("idle_after", idle_e);
    endtask

    initial begin
        idle_e.led = 8'd0; idle_e.busy = 1'b0; idle_e.done = 1'b0; idle_e.idx = 5'd0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        length = 5'd0; reverse = 1'b0; pattern = {PW{1'b0}};
        #2 check_out("reset", idle_e);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_play({66'd0, 3'd5, 3'd2, 3'd7}, 3, 1'b0, -1, -1, -1);
        run_play({66'd0, 3'd5, 3'd2, 3'd7}, 3, 1'b1, -1, -1, -1);
        run_play(rnd_pat(), 0, 1'b0, -1, -1, -1);
        run_play(rnd_pat(), 31, 1'b0, -1, -1, -1);
        run_play(rnd_pat(), 31, 1'b1, -1, -1, -1);
        run_play(rnd_pat(), 5, 1'b0, -1, ON_CYC + OFF_CYC + 1, -1);
        run_play(rnd_pat(), 4, 1'b1, -1, -1, -1);
        run_play(rnd_pat(), 6, 1'b0, 4, -1, -1);
        run_play(rnd_pat(), 4, 1'b1, -1, -1, ON_CYC + OFF_CYC + ON_CYC);
        run_play(rnd_pat(), 2, 1'b0, -1, -1, -1);

        // abort wins over a simultaneous start in IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_out("abort_vs_start", idle_e);

        repeat (20) begin
            run_play(rnd_pat(), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
